// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_pkg
// Purpose  : Shared state encoding, opcode constants and ALU op width for the
//            CPU control sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    localparam int ALU_OP_W = 2;
    localparam int OPC_W    = 4;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    localparam logic [OPC_W-1:0] OPC_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] OPC_ALU  = 4'h1;
    localparam logic [OPC_W-1:0] OPC_LDI  = 4'h2;
    localparam logic [OPC_W-1:0] OPC_JMP  = 4'h8;
    localparam logic [OPC_W-1:0] OPC_JZ   = 4'h9;
    localparam logic [OPC_W-1:0] OPC_JNZ  = 4'hA;
    localparam logic [OPC_W-1:0] OPC_CALL = 4'hC;
    localparam logic [OPC_W-1:0] OPC_RET  = 4'hD;
    localparam logic [OPC_W-1:0] OPC_HALT = 4'hF;

endpackage : cpu_ctrl_pkg
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_decode
// Purpose  : Combinational opcode-to-class decoder. CALL/RET classes exist
//            only when PC_CALL_STACK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output logic             is_branch,
    output logic             is_alu,
    output logic             is_ldi,
    output logic             is_halt,
    output logic             is_call,
    output logic             is_ret
);

    always_comb begin
        is_branch = (opcode == OPC_JMP) || (opcode == OPC_JZ) || (opcode == OPC_JNZ);
        is_alu    = (opcode == OPC_ALU);
        is_ldi    = (opcode == OPC_LDI);
        is_halt   = (opcode == OPC_HALT);
`ifdef PC_CALL_STACK_EN
        is_call   = (opcode == OPC_CALL);
        is_ret    = (opcode == OPC_RET);
`else
        // Without the return register CALL/RET fall through to NOP.
        is_call   = 1'b0;
        is_ret    = 1'b0;
`endif
    end

endmodule : ctrl_decode
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Multi-cycle fetch/decode/execute/write-back sequencer driving the
//            PC and datapath strobes. Optional macro: PC_CALL_STACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int IW   = 8,
    parameter int PCW  = 4,
    parameter int SELW = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IW-1:0]       instr,
    input  logic                imem_ready,
    input  logic [PCW-1:0]      pc,
    input  logic                zero_flag,
    output logic                inc_pc,
    output logic                load_pc,
    output logic [SELW-1:0]     sel_pc,
    output logic                ir_load,
    output logic                alu_en,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                reg_we,
    output logic                halted
);

    state_t          r_state;
    logic [IW-1:0]   r_ir;

    logic [OPC_W-1:0] w_opcode;
    logic [3:0]       w_imm;
    logic             w_is_branch;
    logic             w_is_alu;
    logic             w_is_ldi;
    logic             w_is_halt;
    logic             w_is_call;
    logic             w_is_ret;
    logic             w_taken;

    assign w_opcode = r_ir[IW-1 -: OPC_W];
    assign w_imm    = r_ir[3:0];

    ctrl_decode u_decode (
        .opcode    (w_opcode),
        .is_branch (w_is_branch),
        .is_alu    (w_is_alu),
        .is_ldi    (w_is_ldi),
        .is_halt   (w_is_halt),
        .is_call   (w_is_call),
        .is_ret    (w_is_ret)
    );

    assign w_taken = w_is_branch &&
                     ((w_opcode == OPC_JMP) ||
                      ((w_opcode == OPC_JZ)  &&  zero_flag) ||
                      ((w_opcode == OPC_JNZ) && !zero_flag));

`ifdef PC_CALL_STACK_EN
    logic [PCW-1:0] r_ret_addr;
    logic           r_ret_valid;
`else
    logic w_unused_pc;
    assign w_unused_pc = ^pc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_FETCH;
            r_ir        <= '0;
`ifdef PC_CALL_STACK_EN
            r_ret_addr  <= '0;
            r_ret_valid <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (imem_ready) begin
                        r_ir    <= instr;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (w_is_halt) begin
                        r_state <= ST_HALT;
                    end else if (w_is_alu || w_is_ldi) begin
                        r_state <= ST_EXEC;
                    end else begin
`ifdef PC_CALL_STACK_EN
                        // pc already points past the CALL, i.e. the return address.
                        if (w_is_call) begin
                            r_ret_addr  <= pc;
                            r_ret_valid <= 1'b1;
                        end else if (w_is_ret) begin
                            r_ret_valid <= 1'b0;
                        end
`endif
                        r_state <= ST_FETCH;
                    end
                end
                ST_EXEC:  r_state <= ST_WB;
                ST_WB:    r_state <= ST_FETCH;
                ST_HALT:  r_state <= ST_HALT;
                default:  r_state <= ST_FETCH;
            endcase
        end
    end

    // Strobes are gated by rst_n so that every output is low while reset is held.
    always_comb begin
        inc_pc  = 1'b0;
        load_pc = 1'b0;
        sel_pc  = '0;
        ir_load = 1'b0;
        alu_en  = 1'b0;
        alu_op  = '0;
        reg_we  = 1'b0;
        halted  = 1'b0;
        if (rst_n) begin
            case (r_state)
                ST_FETCH: begin
                    ir_load = imem_ready;
                    inc_pc  = imem_ready;
                end
                ST_DECODE: begin
                    if (w_taken) begin
                        load_pc = 1'b1;
                        sel_pc  = SELW'(w_imm);
                    end
`ifdef PC_CALL_STACK_EN
                    else if (w_is_call) begin
                        load_pc = 1'b1;
                        sel_pc  = SELW'(w_imm);
                    end else if (w_is_ret && r_ret_valid) begin
                        load_pc = 1'b1;
                        sel_pc  = SELW'(r_ret_addr);
                    end
`else
                    else if (w_is_call || w_is_ret) begin
                        load_pc = 1'b0;
                    end
`endif
                end
                ST_EXEC: begin
                    alu_en = 1'b1;
                    alu_op = w_imm[ALU_OP_W-1:0];
                end
                ST_WB:   reg_we = 1'b1;
                ST_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Directed self-checking bench for pc_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] instr;
    logic       imem_ready;
    logic [3:0] pc;
    logic       zero_flag;
    logic       inc_pc, load_pc, ir_load, alu_en, reg_we, halted;
    logic [7:0] sel_pc;
    logic [1:0] alu_op;

    int checks   = 0;
    int failures = 0;

    pc_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .imem_ready (imem_ready),
        .pc         (pc),
        .zero_flag  (zero_flag),
        .inc_pc     (inc_pc),
        .load_pc    (load_pc),
        .sel_pc     (sel_pc),
        .ir_load    (ir_load),
        .alu_en     (alu_en),
        .alu_op     (alu_op),
        .reg_we     (reg_we),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // {inc_pc, load_pc, sel_pc[7:0], ir_load, alu_en, alu_op[1:0], reg_we, halted}
    function automatic logic [15:0] ev(input logic inc, input logic ld, input logic [7:0] sel,
                                       input logic irl, input logic alu, input logic [1:0] op,
                                       input logic we, input logic h);
        return {inc, ld, sel, irl, alu, op, we, h};
    endfunction

    task automatic chk(input string tag, input logic [15:0] exp);
        logic [15:0] got;
        #1;
        got = {inc_pc, load_pc, sel_pc, ir_load, alu_en, alu_op, reg_we, halted};
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    localparam logic [15:0] ZERO  = 16'h0000;
    localparam logic [15:0] FETCH = 16'h8020;  // inc_pc + ir_load

    initial begin
        rst_n = 1'b0; instr = 8'h13; imem_ready = 1'b1; pc = 4'h0; zero_flag = 1'b0;
        cyc(); chk("reset_outputs_zero", ZERO);
        cyc(); rst_n = 1'b1;

        // NOP: 2 cycles, then FETCH again
        instr = 8'h00; imem_ready = 1'b1; chk("nop_fetch", FETCH);
        cyc(); imem_ready = 1'b0; chk("nop_decode", ZERO);
        cyc(); chk("nop_back_fetch_idle", ZERO);

        // ALU 0x13
        instr = 8'h13; imem_ready = 1'b1; chk("alu_fetch", FETCH);
        cyc(); imem_ready = 1'b0; instr = 8'h00; chk("alu_decode", ZERO);
        cyc(); chk("alu_exec", ev(0, 0, 8'h00, 0, 1, 2'd3, 0, 0));
        cyc(); chk("alu_wb", ev(0, 0, 8'h00, 0, 0, 2'd0, 1, 0));
        cyc(); chk("alu_back_fetch", ZERO);

        // JZ 0x95 taken, then not taken
        instr = 8'h95; imem_ready = 1'b1; chk("jz1_fetch", FETCH);
        cyc(); imem_ready = 1'b0; zero_flag = 1'b1; chk("jz_taken", ev(0, 1, 8'h05, 0, 0, 2'd0, 0, 0));
        cyc(); zero_flag = 1'b0; chk("jz1_back_fetch", ZERO);
        imem_ready = 1'b1; chk("jz2_fetch", FETCH);
        cyc(); imem_ready = 1'b0; zero_flag = 1'b0; chk("jz_untaken", ZERO);

        // JMP 0x8A and JNZ 0xA3 both polarities
        cyc(); instr = 8'h8A; imem_ready = 1'b1; zero_flag = 1'b1; chk("jmp_fetch", FETCH);
        cyc(); imem_ready = 1'b0; chk("jmp_taken", ev(0, 1, 8'h0A, 0, 0, 2'd0, 0, 0));
        cyc(); instr = 8'hA3; imem_ready = 1'b1; chk("jnz1_fetch", FETCH);
        cyc(); imem_ready = 1'b0; zero_flag = 1'b0; chk("jnz_taken", ev(0, 1, 8'h03, 0, 0, 2'd0, 0, 0));
        cyc(); imem_ready = 1'b1; chk("jnz2_fetch", FETCH);
        cyc(); imem_ready = 1'b0; zero_flag = 1'b1; chk("jnz_untaken", ZERO);

        // imem_ready low for 3 cycles holds FETCH with no strobes
        cyc(); zero_flag = 1'b0; chk("wait1", ZERO);
        cyc(); chk("wait2", ZERO);
        cyc(); chk("wait3", ZERO);

        // Undefined opcode 0x5F behaves as NOP
        instr = 8'h5F; imem_ready = 1'b1; chk("undef_fetch", FETCH);
        cyc(); imem_ready = 1'b0; chk("undef_decode", ZERO);

        // LDI 0x22
        cyc(); instr = 8'h22; imem_ready = 1'b1; chk("ldi_fetch", FETCH);
        cyc(); imem_ready = 1'b0; chk("ldi_decode", ZERO);
        cyc(); chk("ldi_exec", ev(0, 0, 8'h00, 0, 1, 2'd2, 0, 0));
        cyc(); chk("ldi_wb", ev(0, 0, 8'h00, 0, 0, 2'd0, 1, 0));

        // CALL 0xC9 at pc=4, RET, second RET
        cyc(); instr = 8'hC9; imem_ready = 1'b1; chk("call_fetch", FETCH);
        cyc(); imem_ready = 1'b0; pc = 4'h4;
`ifdef PC_CALL_STACK_EN
        chk("call_decode", ev(0, 1, 8'h09, 0, 0, 2'd0, 0, 0));
`else
        chk("call_decode_nop", ZERO);
`endif
        cyc(); instr = 8'hD0; imem_ready = 1'b1; chk("ret1_fetch", FETCH);
        cyc(); imem_ready = 1'b0; pc = 4'hA;
`ifdef PC_CALL_STACK_EN
        chk("ret1_decode", ev(0, 1, 8'h04, 0, 0, 2'd0, 0, 0));
`else
        chk("ret1_decode_nop", ZERO);
`endif
        cyc(); imem_ready = 1'b1; chk("ret2_fetch", FETCH);
        cyc(); imem_ready = 1'b0; chk("ret2_decode_noload", ZERO);

        // Reset during EXEC aborts without reg_we
        cyc(); instr = 8'h11; imem_ready = 1'b1; chk("abort_fetch", FETCH);
        cyc(); imem_ready = 1'b0; chk("abort_decode", ZERO);
        cyc(); chk("abort_exec", ev(0, 0, 8'h00, 0, 1, 2'd1, 0, 0));
        rst_n = 1'b0; chk("abort_reset_immediate", ZERO);
        cyc(); imem_ready = 1'b1; chk("abort_reset_held", ZERO);
        rst_n = 1'b1; imem_ready = 1'b0; chk("abort_after_release", ZERO);
        cyc(); chk("abort_no_wb", ZERO);
        instr = 8'h00; imem_ready = 1'b1; chk("abort_refetch", FETCH);

        // HALT 0xF0
        cyc(); imem_ready = 1'b0; chk("pre_halt_decode", ZERO);
        cyc(); instr = 8'hF0; imem_ready = 1'b1; chk("halt_fetch", FETCH);
        cyc(); imem_ready = 1'b0; chk("halt_decode", ZERO);
        cyc(); imem_ready = 1'b1; chk("halted1", ev(0, 0, 8'h00, 0, 0, 2'd0, 0, 1));
        cyc(); chk("halted2", ev(0, 0, 8'h00, 0, 0, 2'd0, 0, 1));
        cyc(); rst_n = 1'b0; chk("halt_reset_zero", ZERO);
        cyc(); rst_n = 1'b1; imem_ready = 1'b0; chk("halt_exit_idle", ZERO);
        imem_ready = 1'b1; instr = 8'h00; chk("halt_exit_fetch", FETCH);

        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pc_sequencer
`default_nettype wire
